// File: rtl/nios2vga_fft_out_fifo_if.sv
// Avalon-MM slave bus plus valid/ready stream toward the FFT sink.
// The slave modport is the FIFO's view; master is the CPU/sink side.
interface nios2vga_fft_out_fifo_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_data, out_valid
    );

    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_data, out_valid
    );
endinterface

// File: rtl/nios2vga_fft_out_fifo.sv
// CPU-written sample FIFO streaming to the FFT sink over valid/ready.
// Status exposes empty/full/overflow/level; SENT counts sink handshakes.
module nios2vga_fft_out_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input logic clk,
    input logic reset,
    nios2vga_fft_out_fifo_if.slave bus
);
    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_SENT   = 2'd3;

    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  enable;
    logic                  overflow;
    logic [31:0]           sent;
    logic [DATA_W-1:0]     rd_next;

    logic wr, full, empty;
    logic push_req, push, pop;
    logic flush, ovf_clr, sent_clr;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign full     = (level == LVL_FULL);
    assign empty    = (level == '0);
    assign push_req = wr && (bus.address == A_DATA);
    // Full is judged on the registered level, so a same-cycle pop cannot make room.
    assign push     = push_req && !full;
    assign pop      = bus.out_valid && bus.out_ready;
    assign flush    = wr && (bus.address == A_CTRL) && bus.writedata[1];
    assign ovf_clr  = wr && (bus.address == A_STATUS) && bus.writedata[2];
    assign sent_clr = wr && (bus.address == A_SENT);

    assign bus.out_valid = enable && !empty;
    assign bus.out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.writedata;
    end

    always_comb begin
        rd_next = '0;
        case (bus.address)
            A_STATUS: begin
                rd_next[0] = empty;
                rd_next[1] = full;
                rd_next[2] = overflow;
                rd_next[16 +: DEPTH_LOG2+1] = level;
            end
            A_CTRL:  rd_next[0] = enable;
            A_SENT:  rd_next[31:0] = sent;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            enable       <= 1'b0;
            overflow     <= 1'b0;
            sent         <= '0;
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (push && !pop)      level <= level + LVL_ONE;
                else if (!push && pop) level <= level - LVL_ONE;
            end
            if (wr && bus.address == A_CTRL) enable <= bus.writedata[0];
            if (push_req && full)  overflow <= 1'b1;
            else if (ovf_clr)      overflow <= 1'b0;
            if (sent_clr)          sent <= '0;
            else if (pop && !flush) sent <= sent + 32'd1;
        end
    end
endmodule
